// File: rtl/ps2_host_ctrl.sv
// PS/2 host link controller: receives device frames and sends host commands
// over the open-drain clock/data pair, with inhibit, ACK handling and timeouts.
module ps2_host_ctrl #(
   parameter int INHIBIT_CYCLES = 1600,
   parameter int TIMEOUT_CYCLES = 32000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_err,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   output logic       busy
);

   localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] START_AT     = CNT_W'(INHIBIT_CYCLES - 2);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, RX, TX_INHIBIT, TX_START, TX_BITS, TX_ACK, TX_WAIT
   } state_t;

   state_t           state;
   logic             clk_meta, clk_s, clk_s_prev;
   logic             data_meta, data_s;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       bit_cnt;
   logic [9:0]       rx_frame;
   logic [10:0]      rx_next;
   logic [9:0]       tx_shift;
   logic             ack_ok;
   logic             fall, active, timeout, frame_good;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_meta   <= 1'b0;
         clk_s      <= 1'b0;
         clk_s_prev <= 1'b0;
         data_meta  <= 1'b0;
         data_s     <= 1'b0;
      end else begin
         clk_meta   <= ps2_clk_in;
         clk_s      <= clk_meta;
         clk_s_prev <= clk_s;
         data_meta  <= ps2_data_in;
         data_s     <= data_meta;
      end
   end

   assign fall       = clk_s_prev & ~clk_s;
   assign rx_next    = {data_s, rx_frame};
   assign frame_good = ~rx_next[0] & rx_next[10] & (^rx_next[9:1]);
   assign active     = state inside {RX, TX_START, TX_BITS, TX_ACK, TX_WAIT};
   assign timeout    = active & ~fall & (cnt == TIMEOUT_LAST);
   assign tx_ready   = (state == IDLE) & clk_s;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_cnt     <= '0;
         rx_frame    <= '0;
         tx_shift    <= '0;
         ack_ok      <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         rx_data     <= 8'h00;
         rx_valid    <= 1'b0;
         rx_err      <= 1'b0;
         tx_done     <= 1'b0;
         tx_err      <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         tx_done  <= 1'b0;
         tx_err   <= 1'b0;
         if (fall) cnt <= '0;
         else      cnt <= cnt + 1'b1;

         if (timeout) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            if (state == RX) rx_err <= 1'b1;
            else             tx_err <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  cnt <= '0;
                  if (fall) begin
                     rx_frame <= {data_s, 9'b0};
                     bit_cnt  <= 4'd1;
                     state    <= RX;
                  end else if (tx_valid && tx_ready) begin
                     tx_shift   <= {1'b1, ~^tx_data, tx_data};
                     ps2_clk_oe <= 1'b1;
                     state      <= TX_INHIBIT;
                  end
               end
               RX: begin
                  if (fall) begin
                     rx_frame <= rx_next[10:1];
                     bit_cnt  <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd10) begin
                        if (frame_good) begin
                           rx_data  <= rx_next[8:1];
                           rx_valid <= 1'b1;
                        end else begin
                           rx_err <= 1'b1;
                        end
                        state <= IDLE;
                     end
                  end
               end
               // Our own clock pull-down produces a fall here, so the inhibit count ignores falls.
               TX_INHIBIT: begin
                  cnt <= cnt + 1'b1;
                  if (cnt == START_AT) ps2_data_oe <= 1'b1;
                  if (cnt == INHIBIT_LAST) begin
                     ps2_clk_oe <= 1'b0;
                     cnt        <= '0;
                     state      <= TX_START;
                  end
               end
               TX_START: begin
                  if (fall) begin
                     ps2_data_oe <= ~tx_shift[0];
                     tx_shift    <= {1'b1, tx_shift[9:1]};
                     bit_cnt     <= 4'd1;
                     state       <= TX_BITS;
                  end
               end
               TX_BITS: begin
                  if (fall) begin
                     tx_shift <= {1'b1, tx_shift[9:1]};
                     bit_cnt  <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd9) begin
                        ps2_data_oe <= 1'b0;
                        state       <= TX_ACK;
                     end else begin
                        ps2_data_oe <= ~tx_shift[0];
                     end
                  end
               end
               TX_ACK: begin
                  if (fall) begin
                     ack_ok <= ~data_s;
                     if (data_s) tx_err <= 1'b1;
                     state <= TX_WAIT;
                  end
               end
               TX_WAIT: begin
                  if (clk_s && data_s) begin
                     tx_done <= ack_ok;
                     cnt     <= '0;
                     state   <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
